// File: rtl/fft_in_framer.sv
// Ping-pong input framer for the FFT: collects N complex samples per bank and
// streams each full bank out as N gap-free samples, one cycle after it fills.
module fft_in_framer #(
    parameter int DW = 9,
    parameter int N  = 32,
    localparam int AW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im,
    output logic                 out_valid,
    output logic                 out_sof,
    output logic [AW-1:0]        out_idx
);

    typedef enum logic {IDLE, STREAM} state_t;

    logic [2*DW-1:0] mem_q [2][N];

    state_t        state_q, state_d;
    logic [1:0]    full_q, full_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic          vld_q, vld_d;
    logic          sof_q, sof_d;
    logic [DW-1:0] re_q, re_d;
    logic [DW-1:0] im_q, im_d;

    logic            accept;
    logic            last_wr;
    logic            rd_sel_bank;
    logic [2*DW-1:0] rd_word;

    always_comb begin
        in_ready    = ~full_q[wr_bank_q];
        accept      = in_valid & in_ready & ~flush;
        last_wr     = (wr_cnt_q == AW'(N - 1));
        wr_cnt_d    = wr_cnt_q;
        wr_bank_d   = wr_bank_q;
        full_d      = full_q;
        rd_bank_d   = rd_bank_q;
        rd_cnt_d    = rd_cnt_q;
        state_d     = state_q;
        vld_d       = 1'b0;
        sof_d       = 1'b0;
        rd_sel_bank = rd_bank_q;

        case (state_q)
            IDLE: begin
                rd_cnt_d = '0;
                if (full_q[rd_bank_q]) begin
                    state_d = STREAM;
                    vld_d   = 1'b1;
                    sof_d   = 1'b1;
                end
            end
            STREAM: begin
                if (rd_cnt_q != AW'(N - 1)) begin
                    vld_d    = 1'b1;
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end else begin
                    // Frame done: free this bank and chain straight into the other if ready.
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                    rd_sel_bank       = ~rd_bank_q;
                    rd_cnt_d          = '0;
                    if (full_q[~rd_bank_q]) begin
                        vld_d = 1'b1;
                        sof_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Set after the read-side clear; the two never target the same bank.
        if (flush) begin
            wr_cnt_d = '0;
        end else if (accept) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (last_wr) begin
                wr_cnt_d          = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end

        rd_word = mem_q[rd_sel_bank][rd_cnt_d];
        re_d    = vld_d ? rd_word[2*DW-1:DW] : '0;
        im_d    = vld_d ? rd_word[DW-1:0]    : '0;
    end

    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_bank_q][wr_cnt_q] <= {in_re, in_im};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            vld_q     <= 1'b0;
            sof_q     <= 1'b0;
            re_q      <= '0;
            im_q      <= '0;
        end else begin
            state_q   <= state_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            vld_q     <= vld_d;
            sof_q     <= sof_d;
            re_q      <= re_d;
            im_q      <= im_d;
        end
    end

    assign out_re    = re_q;
    assign out_im    = im_q;
    assign out_valid = vld_q;
    assign out_sof   = sof_q;
    assign out_idx   = rd_cnt_q;

endmodule

// File: tb/tb_fft_in_framer.sv
// Randomized directed bench for fft_in_framer against a queue-based frame model.
module tb_fft_in_framer;
    localparam int DW = 9;
    localparam int N  = 32;
    localparam int AW = $clog2(N);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_re, in_im;
    logic signed [DW-1:0] out_re, out_im;
    logic                 out_valid, out_sof;
    logic [AW-1:0]        out_idx;

    fft_in_framer #(.DW(DW), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im),
        .out_re(out_re), .out_im(out_im),
        .out_valid(out_valid), .out_sof(out_sof), .out_idx(out_idx)
    );

    always #5 clk = ~clk;

    // Model: completed frames concatenated in fq (streaming one first),
    // partial frame in pq, pos = index being presented or -1.
    logic [2*DW-1:0] fq[$];
    logic [2*DW-1:0] pq[$];
    int pos = -1;
    int vectors = 0;
    int errs = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        logic [2*DW-1:0] w;
        w = (pos >= 0) ? fq[pos] : '0;
        chk("in_ready",  32'(in_ready),  32'(fq.size() < 2 * N));
        chk("out_valid", 32'(out_valid), 32'(pos >= 0));
        chk("out_sof",   32'(out_sof),   32'(pos == 0));
        chk("out_idx",   32'(out_idx),   (pos >= 0) ? 32'(pos) : 32'd0);
        chk("out_re",    32'($unsigned(out_re)), 32'(w[2*DW-1:DW]));
        chk("out_im",    32'($unsigned(out_im)), 32'(w[DW-1:0]));
    endtask

    task automatic model(input bit v, input bit fl, input logic [DW-1:0] re,
                         input logic [DW-1:0] im, output bit acc);
        int nfr;
        nfr = fq.size() / N;
        acc = v && (nfr < 2) && !fl;
        if (pos < 0) begin
            if (nfr > 0) pos = 0;
        end else if (pos < N - 1) begin
            pos++;
        end else begin
            repeat (N) void'(fq.pop_front());
            pos = (nfr >= 2) ? 0 : -1;
        end
        if (fl) pq.delete();
        else if (acc) begin
            pq.push_back({re, im});
            if (pq.size() == N) begin
                foreach (pq[k]) fq.push_back(pq[k]);
                pq.delete();
            end
        end
    endtask

    task automatic step(input bit v, input bit fl, input logic [DW-1:0] re,
                        input logic [DW-1:0] im, output bit acc);
        @(negedge clk);
        chk_all();
        in_valid = v;
        flush    = fl;
        in_re    = re;
        in_im    = im;
        model(v, fl, re, im, acc);
    endtask

    task automatic idle(input int cycles);
        bit a;
        repeat (cycles) step(1'b0, 1'b0, '0, '0, a);
    endtask

    task automatic send(input int cnt, input int duty, input bit ramp);
        int sent = 0;
        int guard = 0;
        bit a, v;
        logic [DW-1:0] r, i;
        r = ramp ? '0 : DW'($urandom);
        i = ramp ? '0 : DW'($urandom);
        while (sent < cnt && guard < cnt * 50) begin
            v = (duty >= 100) || ($urandom_range(0, 99) < duty);
            step(v, 1'b0, r, i, a);
            if (a) begin
                sent++;
                r = ramp ? DW'(sent) : DW'($urandom);
                i = ramp ? DW'(-sent) : DW'($urandom);
            end
            guard++;
        end
        chk("send_done", 32'(sent), 32'(cnt));
    endtask

    initial begin
        bit a;
        int guard;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0;
        repeat (2) @(posedge clk);
        #1 chk_all();
        @(negedge clk) rst_n = 1'b1;

        // Single ramp frame re=k, im=-k.
        send(N, 100, 1'b1);
        idle(N + 8);

        // Three frames at full rate: zero-bubble chaining plus backpressure.
        send(3 * N, 100, 1'b0);
        idle(2 * N + 8);

        // Bursty input at ~30% duty.
        send(2 * N, 30, 1'b0);
        idle(2 * N + 8);

        // Partial frame then flush (sample presented with flush is dropped).
        send(10, 100, 1'b0);
        step(1'b1, 1'b1, DW'($urandom), DW'($urandom), a);
        send(N, 100, 1'b0);
        idle(N + 8);

        // Flush while a frame streams must not disturb it.
        send(N, 100, 1'b0);
        idle(4);
        step(1'b0, 1'b1, '0, '0, a);
        idle(N + 4);

        // Reset asserted mid-frame at out_idx 12.
        send(N, 100, 1'b0);
        guard = 0;
        while (pos != 12 && guard < 100) begin
            idle(1);
            guard++;
        end
        chk("reach_idx12", 32'(pos), 32'd12);
        @(negedge clk);
        chk_all();
        in_valid = 1'b0;
        flush    = 1'b0;
        rst_n    = 1'b0;
        #1;
        fq.delete();
        pq.delete();
        pos = -1;
        chk_all();
        #2 rst_n = 1'b1;
        send(N, 100, 1'b0);
        idle(N + 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/fft_in_framer.md
FFT_IN_FRAMER -- requirements
Module: fft_in_framer

Interface
REQ-001 SHALL have parameter DW, default 9, meaning the signed sample width per real/imag component.
REQ-002 SHALL have parameter N, default 32, meaning samples per FFT frame (power of two; AW = log2(N)).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous discard of the partially filled write bank.
REQ-006 SHALL have port in_valid  input  1  upstream sample present.
REQ-007 SHALL have port in_ready  output  1  framer can accept a sample this cycle.
REQ-008 SHALL have ports in_re, in_im  input  DW each  signed sample, real/imag.
REQ-009 SHALL have ports out_re, out_im  output  DW each  signed sample to the FFT input (FFTInRe/FFTInIm).
REQ-010 SHALL have port out_valid  output  1  out_re/out_im carry a frame sample.
REQ-011 SHALL have port out_sof  output  1  first sample of a frame (index 0).
REQ-012 SHALL have port out_idx  output  AW  index of the current output sample in its frame.

Function
REQ-013 SHALL provide two sample banks (bank 0, bank 1) of N entries each, one full flag per bank, a write bank pointer and a read bank pointer.
REQ-014 SHALL accept a sample at a rising edge iff in_valid and in_ready are both 1, storing it at index wr_cnt of the write bank and incrementing wr_cnt.
REQ-015 SHALL drive in_ready = NOT full[write bank], from registered state only (no combinational path from in_valid).
REQ-016 SHALL, on the edge accepting sample N-1, set full[write bank], wrap wr_cnt to 0, and toggle the write bank pointer.
REQ-017 SHALL implement a read FSM with states IDLE and STREAM.
REQ-018 SHALL transition IDLE -> STREAM on the first edge where full[read bank] = 1; at that edge, register sample 0 of the read bank to out_re/out_im, with out_valid=1, out_sof=1, and out_idx=0.
REQ-019 SHALL, in STREAM, emit indices 1..N-1 on N-1 consecutive cycles with no gaps; out_valid=1 throughout and out_sof=0.
REQ-020 SHALL, on the edge after index N-1 is presented, clear full[read bank], toggle the read bank pointer, and then either start the next frame (other bank full: index 0 with out_sof=1 on the same edge, zero bubble) or go to IDLE.
REQ-021 SHALL drive out_re=out_im=0, out_valid=0, out_sof=0, and out_idx=0 whenever no frame sample is presented.
REQ-022 SHALL give a latency of exactly 1 cycle: out_valid rises on the edge after the edge accepting sample N-1 when the FSM is IDLE.
REQ-023 SHALL allow a full-flag set on one bank and a clear on the other bank at the same edge, with both taking effect.
REQ-024 SHALL make a bank freed by a read-side clear accept input from the following cycle (in_ready rises one cycle after the clear edge).
REQ-025 SHALL, on flush=1, reset wr_cnt to 0 and discard the partial write-bank contents; full flags, the read FSM and any frame in STREAM SHALL be unaffected; a sample presented with flush=1 SHALL be dropped.
REQ-026 SHALL pass samples bit-exact with no arithmetic, scaling or saturation.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force FSM=IDLE, both full flags=0, both bank pointers=0, wr_cnt=0 and rd_cnt=0, and all outputs to 0 except in_ready.
REQ-028 SHALL drive in_ready=1 during and after reset, since bank 0 is empty.
REQ-029 SHALL, when reset is asserted mid-frame, abandon the frame immediately; sample memory contents need not be cleared.

Verification
REQ-030 SHALL cover single frame: 32 contiguous samples re=k, im=-k -> out_valid high 32 cycles starting 1 cycle after the last accept, out_sof at idx 0, out_re = 0..31.
REQ-031 SHALL cover back-to-back: 96 samples at full rate -> three frames output with zero bubbles between frames, out_sof every 32 cycles.
REQ-032 SHALL cover backpressure: input at full rate with output streaming -> in_ready=0 once both banks are full, rises 1 cycle after a frame ends, and no sample is lost or duplicated.
REQ-033 SHALL cover bursty input: in_valid random at 30% duty -> each frame still output as 32 contiguous cycles, bit-exact.
REQ-034 SHALL cover flush: 10 samples, then flush, then 32 samples -> output frame equals the last 32 samples only.
REQ-035 SHALL cover reset mid-stream: rst_n low at out_idx=12 -> all outputs 0 and in_ready=1 immediately, and the next full frame is output correctly.
